// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: controller states, common command bytes and the
// frame parity helper used by both the host transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync_edge.sv
// Multi-stage synchroniser for a raw PS/2 pin plus a one-cycle falling-edge
// strobe taken at the synchroniser output. Flops reset to the idle-line value.
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic fe_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign fe_o   = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 8 data bits
// plus odd parity clocked out by the device, then ACK check under a watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] send_data,
    input  logic       send_valid,
    output logic       send_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       error
);

    localparam int unsigned TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [3:0]    bitcnt_q;
    logic [8:0]    shift_q;
    logic          ack_ok_q;
    logic          ready_q;
    logic          clk_oe_q;
    logic          dat_oe_q;
    logic          done_q;
    logic          error_q;

    logic clk_sync, clk_fe;
    logic dat_sync, dat_fe_unused;
    logic wd_expire;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (ps2_clk_in),
        .sync_o (clk_sync),
        .fe_o   (clk_fe)
    );

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (ps2_dat_in),
        .sync_o (dat_sync),
        .fe_o   (dat_fe_unused)
    );

    always_comb begin
        timer_d   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        wd_expire = ((state_q == DATA) || (state_q == ACK) || (state_q == WAIT_IDLE))
                    && (timer_q == TO_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ack_ok_q <= 1'b0;
            ready_q  <= 1'b1;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            // Watchdog expiry overrides any edge seen in the same cycle.
            if (wd_expire) begin
                state_q  <= IDLE;
                ready_q  <= 1'b1;
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                error_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (send_valid && ready_q) begin
                            shift_q  <= {ps2_odd_parity(send_data), send_data};
                            timer_q  <= '0;
                            clk_oe_q <= 1'b1;
                            ready_q  <= 1'b0;
                            state_q  <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (timer_q == INH_LAST) begin
                            clk_oe_q <= 1'b0;
                            dat_oe_q <= 1'b1;
                            timer_q  <= '0;
                            state_q  <= RTS;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                    RTS: begin
                        bitcnt_q <= '0;
                        timer_q  <= timer_d;
                        state_q  <= DATA;
                    end
                    DATA: begin
                        timer_q <= timer_d;
                        if (clk_fe) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd9) begin
                                dat_oe_q <= 1'b0;
                                state_q  <= ACK;
                            end else begin
                                dat_oe_q <= ~shift_q[0];
                                shift_q  <= {1'b0, shift_q[8:1]};
                            end
                        end
                    end
                    ACK: begin
                        timer_q <= timer_d;
                        if (clk_fe) begin
                            ack_ok_q <= ~dat_sync;
                            state_q  <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        timer_q <= timer_d;
                        if (clk_sync && dat_sync) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            done_q  <= ack_ok_q;
                            error_q <= ~ack_ok_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign send_ready = ready_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// DUT and each sampled line bit is compared against a queue filled at request time.
module tb_ps2_host_tx;

    localparam int unsigned INH = 60;
    localparam int unsigned TO  = 2000;
    localparam int unsigned H   = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] send_data = '0;
    logic       send_valid = 1'b0;
    logic       send_ready;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       done, error;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 clock = ~clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .send_data  (send_data),
        .send_valid (send_valid),
        .send_ready (send_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .done       (done),
        .error      (error)
    );

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    int unsigned fail_cnt  = 0;
    int unsigned cyc       = 0;
    int unsigned t_rel     = 0;
    logic        exp_q[$];

    int unsigned done_cnt = 0, err_cnt = 0, done_hi = 0, err_hi = 0, both_hi = 0;
    logic        done_prev = 1'b0, err_prev = 1'b0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (done) done_hi++;
        if (error) err_hi++;
        if (done && !done_prev) done_cnt++;
        if (error && !err_prev) err_cnt++;
        if (done && error) both_hi++;
        done_prev = done;
        err_prev  = error;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [7:0] b);
        logic par;
        par = 1'b1;
        for (int i = 0; i < 8; i++) par = par ^ b[i];
        chk("ready_before_req", send_ready, 1);
        send_data  = b;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
        chk("ready_drop", send_ready, 0);
    endtask

    task automatic check_bit(input string tag);
        logic e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        chk(tag, ps2_dat_in, e);
    endtask

    task automatic inhibit_phase();
        int unsigned n;
        n = 0;
        while (ps2_clk_oe === 1'b1 && n < INH * 4) begin
            n++;
            tick();
        end
        t_rel = cyc;
        chk("inhibit_len", n, INH);
        chk("rts_clk_oe", ps2_clk_oe, 0);
        chk("rts_dat_oe", ps2_dat_oe, 1);
        check_bit("start_bit");
    endtask

    task automatic dev_bit(input string tag, input bit inject);
        if (inject) begin
            send_data  = 8'h55;
            send_valid = 1'b1;
            tick();
            send_valid = 1'b0;
            repeat (H - 1) tick();
        end else begin
            repeat (H) tick();
        end
        dev_clk = 1'b0;
        repeat (H) tick();
        check_bit(tag);
        dev_clk = 1'b1;
    endtask

    task automatic dev_ack(input bit ack);
        repeat (H) tick();
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (H) tick();
        dev_clk = 1'b0;
        repeat (H) tick();
        dev_clk = 1'b1;
        dev_dat = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit ack, input int inj);
        int unsigned d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(b);
        inhibit_phase();
        for (int i = 1; i <= 10; i++) dev_bit($sformatf("fe%0d_line_%0h", i, b), i == inj);
        chk("queue_drained", exp_q.size(), 0);
        dev_ack(ack);
        repeat (20) tick();
        chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
        chk("error_pulses", err_cnt - e0, ack ? 0 : 1);
        chk("end_clk_oe", ps2_clk_oe, 0);
        chk("end_dat_oe", ps2_dat_oe, 0);
        chk("end_ready", send_ready, 1);
    endtask

    initial begin
        int unsigned n, d0, e0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", send_ready, 1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;
        repeat (5) tick();

        frame(8'hED, 1'b1, 0);
        frame(8'hF4, 1'b1, 0);
        frame(8'h00, 1'b1, 0);
        frame(8'hF4, 1'b0, 0);

        // Device never clocks after RTS: watchdog must fire.
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'hFF);
        inhibit_phase();
        n = 0;
        while (error !== 1'b1 && n < TO + 100) begin
            n++;
            tick();
        end
        chk("timeout_latency", cyc - t_rel, TO);
        chk("timeout_clk_oe", ps2_clk_oe, 0);
        chk("timeout_dat_oe", ps2_dat_oe, 0);
        chk("timeout_ready", send_ready, 1);
        exp_q.delete();
        repeat (5) tick();
        chk("timeout_err_pulses", err_cnt - e0, 1);
        chk("timeout_done_pulses", done_cnt - d0, 0);

        // Reset mid-frame after fe5.
        d0 = done_cnt;
        e0 = err_cnt;
        send_req(8'hFF);
        inhibit_phase();
        for (int i = 1; i <= 5; i++) dev_bit($sformatf("rst_fe%0d", i), 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_dat_oe", ps2_dat_oe, 0);
        chk("midrst_ready", send_ready, 1);
        repeat (5) tick();
        reset = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        chk("midrst_done_pulses", done_cnt - d0, 0);
        chk("midrst_err_pulses", err_cnt - e0, 0);
        frame(8'hF4, 1'b1, 0);

        // Request during DATA must be dropped, not queued.
        frame(8'hED, 1'b1, 4);
        repeat (INH) tick();
        chk("ignored_req_clk_oe", ps2_clk_oe, 0);
        chk("ignored_req_ready", send_ready, 1);

        chk("total_done", done_cnt, 5);
        chk("total_error", err_cnt, 2);
        chk("done_one_cycle", done_hi, done_cnt);
        chk("error_one_cycle", err_hi, err_cnt);
        chk("done_error_overlap", both_hi, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the PS/2 link whose receive side feeds keyboard_tracker.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable) using the open-collector clock-inhibit / request-to-send sequence, then checks the device ACK.
- Sits between the top level (which owns the PS2_CLK/PS2_DAT tristates) and command logic (LED mirroring of rate/colour toggles).

Parameters:
- INHIBIT_CYCLES, 6000, clock cycles PS2_CLK is held low before request-to-send (120 us @ 50 MHz).
- TIMEOUT_CYCLES, 750000, watchdog limit from clock release to ACK completion (15 ms @ 50 MHz).
- SYNC_STAGES, 2, synchroniser depth on ps2_clk_in and ps2_dat_in.

Ports:
- clock  in  1  system clock (CLOCK_50 at top).
- reset  in  1  asynchronous, active-high reset.
- send_data  in  8  byte to transmit.
- send_valid  in  1  request; accepted only when send_ready=1.
- send_ready  out  1  high in IDLE only.
- ps2_clk_in  in  1  raw PS2_CLK pin value.
- ps2_dat_in  in  1  raw PS2_DAT pin value.
- ps2_clk_oe  out  1  1 = top drives PS2_CLK low; 0 = release (Z).
- ps2_dat_oe  out  1  1 = top drives PS2_DAT low; 0 = release (Z).
- done  out  1  one-cycle pulse: byte sent and ACK received.
- error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset (async, immediate): state IDLE; send_ready=1; clk_oe=0; dat_oe=0; done=0; error=0; shift register, counters and synchronisers cleared. Synchroniser flops reset to 1 (idle-line value).
- Falling-edge detect: a PS/2 clock edge (fe) is a 1->0 transition at the synchroniser output. fe is one cycle wide.
- IDLE: on send_valid & send_ready, latch {parity, send_data}.
  - parity = ~^send_data (odd parity).
  - Go to INHIBIT. send_ready drops on the next cycle.
- INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles. Then go to RTS.
- RTS: dat_oe=1 (start bit 0), clk_oe=0 from this cycle. Watchdog cleared and starts counting. bitcnt=0. Go to DATA.
- DATA: on each fe, bitcnt increments and the line is updated.
  - fe 1..8 present data bit 0..7, LSB first: dat_oe = ~bit.
  - fe 9 presents parity.
  - fe 10 sets dat_oe=0 (stop bit via pull-up); go to ACK.
  - The line changes only in the cycle after fe is detected; there is no other data-line change.
- ACK: on the next fe, sample the synchronised data line.
  - 0 -> go to WAIT_IDLE with ack_ok=1.
  - 1 -> go to WAIT_IDLE with ack_ok=0.
- WAIT_IDLE: wait until both synchronised lines read 1, then go to IDLE.
  - On that transition, pulse done if ack_ok, else pulse error.
- Watchdog: counts in DATA, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES-1:
  - release both lines, pulse error, go to IDLE;
  - any fe in that same cycle is ignored.
- send_valid while send_ready=0 is ignored; it is not queued.
- done and error are never both high, and never high while reset is asserted.
- Reset asserted mid-frame releases both lines in the same cycle (async) and emits no done or error pulse.
- Widths: bitcnt 4 bits. Timers sized $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)). No wrap: timers saturate or clear on state entry.

Decomposition:
- Shared package (ps2_pkg):
  - state enum {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE};
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF.
  - The existing PS/2 receiver shares the package.
- One sub-module, ps2_sync_edge: SYNC_STAGES synchroniser plus falling-edge detector. Instantiated twice here and reusable by the receiver.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz (40 us half-period) and ACKs. Required response:
  - clk_oe high 6000 cycles;
  - bits after fe 1..9 = 1,0,1,1,0,1,1,1, parity 1;
  - line released at fe 10;
  - done pulses once after both lines go high;
  - send_ready returns to 1.
- Send 0xF4 (five ones) -> parity bit 0; done pulses. Repeat with 0x00 -> parity 1.
- Device holds data high at fe 11 (NACK) -> error pulses for one cycle, done stays 0, both oe=0, state IDLE.
- Device never clocks after RTS -> exactly TIMEOUT_CYCLES cycles after clock release, error pulses and both oe return to 0.
- Assert reset after fe 5 of a 0xFF frame -> clk_oe=dat_oe=0 in the same cycle; no done or error pulse. A new 0xF4 request after reset completes normally.
- Pulse send_valid with 0x55 during DATA of a 0xED frame -> ignored; only 0xED bits appear on the line; exactly one done pulse.
